// File: rtl/mydiv.sv
// Sequential signed fixed-point divider c = a / b with a restoring datapath
// that retires one quotient bit per cycle; results saturate on overflow or divide-by-zero.
module mydiv #(
  parameter int a_bits  = 16,
  parameter int a_point = 8,
  parameter int b_bits  = 16,
  parameter int b_point = 8,
  parameter int c_bits  = 16,
  parameter int c_point = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [a_bits-1:0] a,
  input  logic [b_bits-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [c_bits-1:0] c,
  output logic              ovf,
  output logic              div0
);

  localparam int shift    = c_point + b_point - a_point;
  localparam int shift_nn = (shift < 0) ? 0 : shift;
  localparam int num_w    = (a_bits + shift_nn > c_bits) ? a_bits + shift_nn : c_bits;
  localparam int cmp_w    = num_w + b_bits;
  localparam int cnt_w    = (c_bits > 1) ? $clog2(c_bits) : 1;

  localparam logic [c_bits-1:0] c_min = c_bits'(1) << (c_bits - 1);
  localparam logic [c_bits-1:0] c_max = ~c_min;

  generate
    if (shift < 0) begin : g_shift_check
      $error("mydiv: c_point + b_point - a_point must not be negative");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CHECK, DIV, DONE} state_t;

  state_t            state, state_nx;
  logic              sign_q, a_zero_q, b_zero_q, chk_ovf_q;
  logic [a_bits-1:0] mag_a;
  logic [b_bits-1:0] mag_b;
  logic [b_bits-1:0] rem;
  logic [c_bits-1:0] quo;
  logic [cnt_w-1:0]  cnt;

  // Magnitudes are unsigned, so negating the most negative value yields 2^(n-1) exactly.
  logic [a_bits-1:0] abs_a;
  logic [b_bits-1:0] abs_b;
  assign abs_a = a[a_bits-1] ? -a : a;
  assign abs_b = b[b_bits-1] ? -b : b;

  logic [num_w-1:0] num, hi;
  logic             chk_ovf, num_bit, ge;
  logic [b_bits:0]  rem_sh;
  logic [b_bits-1:0] rem_nx;
  logic [c_bits-1:0] quo_nx, sat_val, res_c;
  logic              res_ovf;

  assign num     = num_w'(mag_a) << shift_nn;
  assign hi      = num >> c_bits;
  assign chk_ovf = cmp_w'(hi) >= cmp_w'(mag_b);
  assign num_bit = |(num & (num_w'(1) << cnt));

  // Remainder stays below |b|, so one extra bit suffices for the trial subtraction.
  assign rem_sh  = {rem, num_bit};
  assign ge      = rem_sh >= {1'b0, mag_b};
  assign rem_nx  = ge ? b_bits'(rem_sh - {1'b0, mag_b}) : rem_sh[b_bits-1:0];
  assign quo_nx  = (quo << 1) | c_bits'(ge);

  assign sat_val = sign_q ? c_min : c_max;
  assign res_ovf = chk_ovf_q
                 | (!sign_q && quo_nx[c_bits-1])
                 | ( sign_q && quo_nx[c_bits-1] && (quo_nx != c_min));
  assign res_c   = res_ovf ? sat_val : (sign_q ? -quo_nx : quo_nx);

  assign in_ready = (state == IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: next state is defaulted first so no path through the case infers a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = CHECK;
      CHECK:   state_nx = b_zero_q ? DONE : DIV;
      DIV:     if (cnt == '0) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: datapath registers are few and small, so all of them reset to keep outputs deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q    <= 1'b0;
      a_zero_q  <= 1'b0;
      b_zero_q  <= 1'b0;
      chk_ovf_q <= 1'b0;
      mag_a     <= '0;
      mag_b     <= '0;
      rem       <= '0;
      quo       <= '0;
      cnt       <= '0;
      c         <= '0;
      ovf       <= 1'b0;
      div0      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign_q   <= a[a_bits-1] ^ b[b_bits-1];
          mag_a    <= abs_a;
          mag_b    <= abs_b;
          a_zero_q <= (a == '0);
          b_zero_q <= (b == '0);
        end
        CHECK: if (b_zero_q) begin
          c         <= a_zero_q ? '0 : sat_val;
          ovf       <= !a_zero_q;
          div0      <= 1'b1;
          out_valid <= 1'b1;
        end else begin
          rem       <= b_bits'(hi);
          chk_ovf_q <= chk_ovf;
          quo       <= '0;
          cnt       <= cnt_w'(c_bits - 1);
        end
        DIV: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt - cnt_w'(1);
          if (cnt == '0) begin
            c         <= res_c;
            ovf       <= res_ovf;
            div0      <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mydiv.sv
// Self-checking bench for mydiv (16/8 on every operand): directed vectors with literal
// expectations plus an arithmetic reference model compared against the outputs every cycle.
`timescale 1ns/1ps
module tb_mydiv;

  localparam int     W     = 16;
  localparam longint SCALE = 256;   // 2^(c_point + b_point - a_point)

  typedef struct packed {
    logic [W-1:0] c;
    logic         ovf;
    logic         div0;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, ovf, div0;
  logic [W-1:0] c;

  int n_cmp = 0;
  int n_bad = 0;

  mydiv #(
    .a_bits(16), .a_point(8), .b_bits(16), .b_point(8), .c_bits(16), .c_point(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .ovf(ovf), .div0(div0)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Plain integer arithmetic: scale, divide, truncate toward zero, sign, clamp.
  function automatic res_t model_div(input logic signed [W-1:0] av, input logic signed [W-1:0] bv);
    res_t   r;
    longint na, nb, q, v;
    r.div0 = (bv == 0);
    if (bv == 0) begin
      r.ovf = (av != 0);
      if (av == 0)     r.c = 16'h0000;
      else if (av < 0) r.c = 16'h8000;
      else             r.c = 16'h7fff;
    end else begin
      na = (av < 0) ? -longint'(av) : longint'(av);
      nb = (bv < 0) ? -longint'(bv) : longint'(bv);
      q  = (na * SCALE) / nb;
      v  = ((av < 0) != (bv < 0)) ? -q : q;
      if (v > 32767)       begin r.c = 16'h7fff; r.ovf = 1'b1; end
      else if (v < -32768) begin r.c = 16'h8000; r.ovf = 1'b1; end
      else                 begin r.c = 16'(v);   r.ovf = 1'b0; end
    end
    return r;
  endfunction

  // Transaction-level model: busy from accept to consume, result after a fixed latency.
  logic m_busy, m_valid;
  int   m_cnt;
  res_t m_pend, m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_cnt   <= 0;
      m_pend  <= '0;
      m_res   <= '0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_pend <= model_div(a, b);
        m_busy <= 1'b1;
        m_cnt  <= (b == '0) ? 1 : W + 1;
      end
    end else if (!m_valid) begin
      if (m_cnt == 1) begin
        m_valid <= 1'b1;
        m_res   <= m_pend;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if (out_ready) begin
      m_valid <= 1'b0;
      m_busy  <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("model in_ready",  in_ready,  !m_busy);
      check("model out_valid", out_valid, m_valid);
      check("model c",         c,         m_res.c);
      check("model ovf",       ovf,       m_res.ovf);
      check("model div0",      div0,      m_res.div0);
    end
  end

  task automatic wait_idle(input string name);
    int waited = 0;
    while (!in_ready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    check({name, " idle"}, in_ready, 1);
  endtask

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv);
    a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ec, input logic eo, input logic ed, input int elat);
    int lat;
    wait_idle(name);
    out_ready = 1'b1;
    send(av, bv);
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, lat, elat);
    check({name, " c"},       c,   ec);
    check({name, " ovf"},     ovf, eo);
    check({name, " div0"},    div0, ed);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("reset out_valid", out_valid, 0);
    check("reset in_ready",  in_ready,  1);
    check("reset c",         c,         0);
    check("reset ovf",       ovf,       0);
    check("reset div0",      div0,      0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_op("3.0/2.0",    16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, 18);
    run_op("-1/3",       16'hff00, 16'h0300, 16'hffab, 1'b0, 1'b0, 18);
    run_op("tiny/3",     16'h0001, 16'h0300, 16'h0000, 1'b0, 1'b0, 18);
    run_op("neg/neg",    16'hfd00, 16'hfe00, 16'h0180, 1'b0, 1'b0, 18);
    run_op("max/1lsb",   16'h7fff, 16'h0001, 16'h7fff, 1'b1, 1'b0, 18);
    run_op("min/1lsb",   16'h8000, 16'h0001, 16'h8000, 1'b1, 1'b0, 18);
    run_op("exact min",  16'hff00, 16'h0002, 16'h8000, 1'b0, 1'b0, 18);
    run_op("pos 2^15",   16'h4000, 16'h0080, 16'h7fff, 1'b1, 1'b0, 18);
    run_op("min/min",    16'h8000, 16'h8000, 16'h0100, 1'b0, 1'b0, 18);
    run_op("max/-1lsb",  16'h7fff, 16'hffff, 16'h8000, 1'b1, 1'b0, 18);
    run_op("1.0/0",      16'h0100, 16'h0000, 16'h7fff, 1'b1, 1'b1, 2);
    run_op("-1.0/0",     16'hff00, 16'h0000, 16'h8000, 1'b1, 1'b1, 2);
    run_op("0/0",        16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 2);

    // Result must hold under backpressure while new operands are refused.
    wait_idle("bp");
    out_ready = 1'b0;
    send(16'h0500, 16'h0200);
    for (int i = 0; i < 60 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 10; i++) begin
      check("bp out_valid", out_valid, 1);
      check("bp in_ready",  in_ready,  0);
      check("bp c",         c,         16'h0280);
      in_valid = i[0];
      a = 16'h0100; b = 16'h0100;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp consumed", out_valid, 0);
    check("bp reopened", in_ready,  1);
    run_op("after bp", 16'h0100, 16'h0300, 16'h0055, 1'b0, 1'b0, 18);

    // Asynchronous reset in the middle of an iteration discards the operation.
    wait_idle("rst");
    send(16'h0300, 16'h0200);
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst out_valid", out_valid, 0);
    check("rst in_ready",  in_ready,  1);
    check("rst c",         c,         0);
    check("rst ovf",       ovf,       0);
    check("rst div0",      div0,      0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op("post rst", 16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, 18);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
